modbus_frame_checker: RTL

Receive-side Modbus RTU frame checker that sits between the UART byte receiver and the request decoder. It consumes the received byte stream of one frame, delimited by frame_start and frame_end. It computes CRC-16/MODBUS (reflected polynomial 0xA001, init 0xFFFF, no final XOR) over every byte except the trailing two, then compares that result with the two received CRC bytes (low byte first). It reports per-frame status: CRC match, length error and address miss.

---
 rtl/modbus_frame_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/modbus_frame_checker.sv
// Modbus RTU receive-side frame checker: CRC-16/MODBUS, length and optional address check.
// Optional address filter enabled by defining MODBUS_ADDR_FILTER_EN.
module modbus_frame_checker #(
  parameter int MIN_LEN = 4,
  parameter int MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        frame_end,
  input  logic [7:0]  slave_addr,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic        addr_miss,
  output logic [8:0]  byte_count,
  output logic [15:0] calc_crc,
  output logic [15:0] rx_crc
);

  localparam logic [8:0] CNT_SAT = 9'(MAX_LEN + 1);
  localparam logic [8:0] CNT_MIN = 9'(MIN_LEN);
  localparam logic [8:0] CNT_MAX = 9'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] crc_run, crc_d1, crc_d2;
  logic [15:0] crc_run_n, crc_d1_n, crc_d2_n;
  logic [7:0]  sh_last, sh_prev, addr_byte;
  logic [7:0]  sh_last_n, sh_prev_n, addr_byte_n;
  logic [8:0]  count, count_n;
  logic        take_byte, close;
  logic        crc_err_n, len_err_n, addr_miss_n;
  logic        crc_err_q, len_err_q, addr_miss_q, frame_ok_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = RECV;
      RECV:    if (frame_start) state_next = RECV;
               else if (frame_end) state_next = DONE;
      DONE:    state_next = frame_start ? RECV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // frame_start clears the accumulators first, so a byte in the same cycle becomes byte 0.
  always_comb begin
    crc_run_n   = frame_start ? 16'hFFFF : crc_run;
    crc_d1_n    = frame_start ? 16'hFFFF : crc_d1;
    crc_d2_n    = frame_start ? 16'hFFFF : crc_d2;
    sh_last_n   = frame_start ? 8'h00 : sh_last;
    sh_prev_n   = frame_start ? 8'h00 : sh_prev;
    addr_byte_n = frame_start ? 8'h00 : addr_byte;
    count_n     = frame_start ? 9'd0 : count;
    take_byte   = byte_valid && (frame_start || state == RECV) && (count_n < CNT_SAT);
    if (take_byte) begin
      crc_d2_n  = crc_d1_n;
      crc_d1_n  = crc_run_n;
      crc_run_n = crc_byte(crc_run_n, byte_data);
      sh_prev_n = sh_last_n;
      sh_last_n = byte_data;
      if (count_n == 9'd0) addr_byte_n = byte_data;
      count_n   = count_n + 9'd1;
    end
  end

  // Status is evaluated on the post-byte values so a byte arriving with frame_end counts.
  always_comb begin
    close       = (state == RECV) && frame_end && !frame_start;
    crc_err_n   = (count_n >= 9'd2) && (crc_d2_n != {sh_last_n, sh_prev_n});
    len_err_n   = (count_n < CNT_MIN) || (count_n > CNT_MAX);
`ifdef MODBUS_ADDR_FILTER_EN
    addr_miss_n = (addr_byte_n != slave_addr) && (addr_byte_n != 8'h00);
`else
    addr_miss_n = 1'b0;
`endif
  end

`ifndef MODBUS_ADDR_FILTER_EN
  logic slave_addr_unused;
  assign slave_addr_unused = ^slave_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      crc_run     <= 16'hFFFF;
      crc_d1      <= 16'hFFFF;
      crc_d2      <= 16'hFFFF;
      sh_last     <= 8'h00;
      sh_prev     <= 8'h00;
      addr_byte   <= 8'h00;
      count       <= 9'd0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      addr_miss_q <= 1'b0;
      frame_ok_q  <= 1'b0;
    end else begin
      state       <= state_next;
      crc_run     <= crc_run_n;
      crc_d1      <= crc_d1_n;
      crc_d2      <= crc_d2_n;
      sh_last     <= sh_last_n;
      sh_prev     <= sh_prev_n;
      addr_byte   <= addr_byte_n;
      count       <= count_n;
      if (frame_start) begin
        crc_err_q   <= 1'b0;
        len_err_q   <= 1'b0;
        addr_miss_q <= 1'b0;
        frame_ok_q  <= 1'b0;
      end else if (close) begin
        crc_err_q   <= crc_err_n;
        len_err_q   <= len_err_n;
        addr_miss_q <= addr_miss_n;
        frame_ok_q  <= !crc_err_n && !len_err_n && !addr_miss_n;
      end
    end
  end

  assign frame_done = (state == DONE);
  assign frame_ok   = frame_ok_q;
  assign crc_err    = crc_err_q;
  assign len_err    = len_err_q;
  assign addr_miss  = addr_miss_q;
  assign byte_count = count;
  assign calc_crc   = crc_d2;
  assign rx_crc     = {sh_last, sh_prev};

endmodule
